fifo_param: RTL

- Parametrised synchronous FIFO; next generation of the transaction-layer 12-bit × 8 FIFO.
- Width, depth and almost-full/almost-empty thresholds are all configurable.
- Adds full/empty flags, an occupancy count, a read-valid strobe and sticky overflow/underflow error flags.
- Used as the per-virtual-channel buffer between transaction-layer stages, feeding and draining on one clock.

---
 rtl/fifo_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with occupancy, threshold flags and sticky errors
// Optional FIFO_FWFT_EN selects first-word-fall-through reads instead of a registered 1-cycle read.
module fifo_param #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   almost_full_thr,
  input  logic [ADDR_WIDTH:0]   almost_empty_thr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  pop_ok, push_ok;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= almost_full_thr);
  assign almost_empty = (count_q <= almost_empty_thr);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a push when a pop frees a slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (ADDR_WIDTH + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (ADDR_WIDTH + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end
      count_q <= count_d;
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_out = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_out_q;

  // data_out keeps the last popped word; only valid_out marks it as fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      valid_out_q <= pop_ok;
      if (pop_ok) begin
        data_out_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
`endif

endmodule
